muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter_pkg.sv | 58 +++++
 rtl/muldiv_iter_cond_neg.sv | 12 +
 rtl/muldiv_iter.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared encodings and operation-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_iter_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic op_signed_a(input op_e op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_signed_b(input op_e op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_div(input op_e op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_rem(input op_e op);
        logic r;
        case (op)
            OP_REM, OP_REMU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_iter_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? ({W{1'b0}} - x) : x;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes, then a sign-fix cycle.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    op_e                op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   opnd_r;      // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;

    op_e                op_in_s;
    logic               sign_a_in_s;
    logic               sign_b_in_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               special_s;
    logic [WIDTH-1:0]   special_res_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic               is_rem_s;
    logic [WIDTH-1:0]   qr_sel_s;
    logic               qr_neg_s;
    logic [WIDTH-1:0]   qr_fix_s;
    logic [WIDTH-1:0]   fix_res_s;

    assign op_in_s     = op_e'(op);
    assign sign_a_in_s = op_signed_a(op_in_s) & a[WIDTH-1];
    assign sign_b_in_s = op_signed_b(op_in_s) & b[WIDTH-1];
    assign div_zero_s  = (b == {WIDTH{1'b0}});
    assign div_ovf_s   = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                         (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    assign special_s   = op_is_div(op_in_s) && (div_zero_s || div_ovf_s);

    cond_neg #(.W(WIDTH)) u_neg_a (.x(a), .neg(sign_a_in_s), .y(mag_a_s));
    cond_neg #(.W(WIDTH)) u_neg_b (.x(b), .neg(sign_b_in_s), .y(mag_b_s));

    // Short-path result for divide-by-zero and signed divide overflow
    always_comb begin
        special_res_s = {WIDTH{1'b1}};
        if (div_zero_s) begin
            special_res_s = op_is_rem(op_in_s) ? a : {WIDTH{1'b1}};
        end else begin
            special_res_s = (op_in_s == OP_REM) ? {WIDTH{1'b0}} : a;
        end
    end

    // One radix-2 iteration of the shift-add multiplier and the restoring divider
    always_comb begin
        if (prod_r[0]) begin
            add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_next_s = {add_s, prod_r[WIDTH-1:1]};
        rem_shift_s = {rem_r, quo_r[WIDTH-1]};
        // The difference is below the divisor whenever it is kept, so WIDTH bits suffice
        diff_s      = rem_shift_s[WIDTH-1:0] - opnd_r;
        if (rem_shift_s >= {1'b0, opnd_r}) begin
            rem_next_s = diff_s;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    assign is_rem_s = op_is_rem(op_r);
    assign qr_sel_s = is_rem_s ? rem_r : quo_r;
    assign qr_neg_s = is_rem_s ? sign_a_r : (sign_a_r ^ sign_b_r);

    cond_neg #(.W(2*WIDTH)) u_neg_prod (.x(prod_r), .neg(sign_a_r ^ sign_b_r), .y(prod_fix_s));
    cond_neg #(.W(WIDTH))   u_neg_qr   (.x(qr_sel_s), .neg(qr_neg_s), .y(qr_fix_s));

    // Select the architectural result from the sign-corrected datapath
    always_comb begin
        case (op_r)
            OP_MUL:                      fix_res_s = prod_fix_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            default:                     fix_res_s = qr_fix_s;
        endcase
    end

    // Control FSM with registered handshake outputs and iteration datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= OP_MUL;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_r     <= op_in_s;
                        sign_a_r <= sign_a_in_s;
                        sign_b_r <= sign_b_in_s;
                        cnt_r    <= CNT_INIT;
                        ready    <= 1'b0;
                        if (special_s) begin
                            result  <= special_res_s;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            busy    <= 1'b1;
                            state_r <= S_CALC;
                        end
                        if (op_is_div(op_in_s)) begin
                            opnd_r <= mag_b_s;
                            quo_r  <= mag_a_s;
                            rem_r  <= {WIDTH{1'b0}};
                            prod_r <= {(2*WIDTH){1'b0}};
                        end else begin
                            opnd_r <= mag_a_s;
                            prod_r <= {{WIDTH{1'b0}}, mag_b_s};
                            quo_r  <= {WIDTH{1'b0}};
                            rem_r  <= {WIDTH{1'b0}};
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                        if (op_is_div(op_r)) begin
                            rem_r <= rem_next_s;
                            quo_r <= quo_next_s;
                        end else begin
                            prod_r <= prod_next_s;
                        end
                        state_r <= (cnt_r == CNT_ONE) ? S_FIX : S_CALC;
                    end
                end
                S_FIX: begin
                    busy <= 1'b0;
                    if (kill) begin
                        ready   <= 1'b1;
                        state_r <= S_IDLE;
                    end else begin
                        result  <= fix_res_s;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready   <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter with WIDTH=32 and hand-computed results.
module tb_muldiv_iter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, and check result/latency/busy time
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_res,
                          input int exp_cyc, input int exp_busy);
        int   cyc;
        int   bcnt;
        logic seen;
        cyc  = 0;
        bcnt = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            start = 1'b0; a = ~av; b = bv + 32'd1; op = ~o;
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        check({tag, "/done"}, {31'd0, seen}, 32'd1);
        check({tag, "/res"}, result, exp_res);
        check({tag, "/cyc"}, cyc, exp_cyc);
        check({tag, "/busy"}, bcnt, exp_busy);
        @(posedge clk); #1;
        check({tag, "/ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int dcnt;
        reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        check("rst/ready", {31'd0, ready}, 32'd1);
        check("rst/busy", {31'd0, busy}, 32'd0);
        check("rst/done", {31'd0, done}, 32'd0);
        check("rst/result", result, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op("mul",     3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33);
        run_op("mulh",    3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34, 33);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33);
        run_op("mul_min", 3'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 34, 33);
        run_op("div",     3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34, 33);
        run_op("rem",     3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34, 33);
        run_op("divu",    3'd5, 32'd100,        32'd7,        32'd14,       34, 33);
        run_op("remu",    3'd7, 32'd100,        32'd7,        32'd2,        34, 33);
        run_op("div0",    3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("rem0",    3'd6, 32'd5,          32'd0,        32'd5,        1, 0);
        run_op("remu0",   3'd7, 32'd9,          32'd0,        32'd9,        1, 0);
        run_op("div_ovf", 3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ovf", 3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1, 0);
        run_op("divu_big", 3'd5, 32'h80000000,  32'hFFFFFFFF, 32'd0,        34, 33);
        run_op("remu_big", 3'd7, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 34, 33);

        // Kill mid-CALC: no done, back to ready, result untouched
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check("kill/ready", {31'd0, ready}, 32'd1);
        check("kill/busy", {31'd0, busy}, 32'd0);
        count_done(40, dcnt);
        check("kill/no_done", dcnt, 32'd0);
        check("kill/result", result, 32'h80000000);

        // Start during CALC is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 60 && dcnt == 0; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("ign/done", dcnt, 32'd1);
        check("ign/result", result, 32'd14);
        count_done(40, dcnt);
        check("ign/no_second", dcnt, 32'd0);
        check("ign/result_hold", result, 32'd14);

        // kill and start together in IDLE: start not accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5;
        @(posedge clk); #1; start = 1'b0; kill = 1'b0;
        check("kstart/ready", {31'd0, ready}, 32'd1);
        check("kstart/busy", {31'd0, busy}, 32'd0);
        count_done(40, dcnt);
        check("kstart/no_done", dcnt, 32'd0);

        // Asynchronous reset between edges mid-CALC
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3; reset_n = 1'b0; #1;
        check("arst/busy", {31'd0, busy}, 32'd0);
        check("arst/done", {31'd0, done}, 32'd0);
        check("arst/result", result, 32'd0);
        check("arst/ready", {31'd0, ready}, 32'd1);
        @(negedge clk); reset_n = 1'b1;
        run_op("post_rst", 3'd5, 32'd9, 32'd3, 32'd3, 34, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
